// File: rtl/sc_isa_pkg.sv
// MIPS subset ISA constants shared by the instruction encoder and decoder-side benches:
// opcode/func codes, mnemonic codes, field widths and word-assembly helpers.
package sc_isa_pkg;

    localparam int REG_W  = 5;
    localparam int OP_W   = 6;
    localparam int FUNC_W = 6;
    localparam int IMM_W  = 16;
    localparam int TGT_W  = 26;
    localparam int WORD_W = 32;
    localparam int MNEM_W = 5;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0c;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0e;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

    localparam logic [FUNC_W-1:0] FN_SLL = 6'h00;
    localparam logic [FUNC_W-1:0] FN_SRL = 6'h02;
    localparam logic [FUNC_W-1:0] FN_SRA = 6'h03;
    localparam logic [FUNC_W-1:0] FN_JR  = 6'h08;
    localparam logic [FUNC_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNC_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNC_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNC_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNC_W-1:0] FN_XOR = 6'h26;

    typedef enum logic [MNEM_W-1:0] {
        MN_ADD  = 5'd0,  MN_SUB  = 5'd1,  MN_AND  = 5'd2,  MN_OR   = 5'd3,
        MN_XOR  = 5'd4,  MN_SLL  = 5'd5,  MN_SRL  = 5'd6,  MN_SRA  = 5'd7,
        MN_JR   = 5'd8,  MN_ADDI = 5'd9,  MN_ANDI = 5'd10, MN_ORI  = 5'd11,
        MN_XORI = 5'd12, MN_LW   = 5'd13, MN_SW   = 5'd14, MN_BEQ  = 5'd15,
        MN_BNE  = 5'd16, MN_LUI  = 5'd17, MN_J    = 5'd18, MN_JAL  = 5'd19
    } mnem_e;

    function automatic logic [WORD_W-1:0] r_word(input logic [REG_W-1:0] rs,
                                                 input logic [REG_W-1:0] rt,
                                                 input logic [REG_W-1:0] rd,
                                                 input logic [REG_W-1:0] sa,
                                                 input logic [FUNC_W-1:0] fn);
        return {OP_RTYPE, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [WORD_W-1:0] i_word(input logic [OP_W-1:0] op,
                                                 input logic [REG_W-1:0] rs,
                                                 input logic [REG_W-1:0] rt,
                                                 input logic [IMM_W-1:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [WORD_W-1:0] j_word(input logic [OP_W-1:0] op,
                                                 input logic [TGT_W-1:0] tgt);
        return {op, tgt};
    endfunction

endpackage

// File: rtl/sc_word_fifo.sv
// Synchronous word FIFO with occupancy count; clear flushes it in one cycle.
// Pushes while full and pops while empty are ignored.
module sc_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage array: data path only, contents are qualified by the count.
    always_ff @(posedge clock) begin
        if (push_ok_s && !clear) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; reset and clear both empty the buffer.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/sc_instr_encoder.sv
// Streaming MIPS instruction encoder/loader: encodes one mnemonic beat per handshake and
// writes the words into imem at consecutive addresses. `SC_ENC_CHECKSUM_EN adds a checksum port.
module sc_instr_encoder
    import sc_isa_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_sa,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              mem_grant,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   wr_count,
    output logic              overflow,
    output logic              err_illegal
`ifdef SC_ENC_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WCNT_W = ADDR_W + 1;
    localparam int SUM_W  = ADDR_W + 2;
    localparam logic [SUM_W-1:0]  CAP_L  = {2'b01, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BASE_L = ADDR_W'(BASE_ADDR);

    mnem_e              mnem_s;
    logic [31:0]        enc_word_s;
    logic               enc_legal_s;
    logic [31:0]        fifo_rdata_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic [SUM_W-1:0]   occ_sum_s;
    logic               cap_ok_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    logic [WCNT_W-1:0]  wr_count_r;
    logic [ADDR_W-1:0]  mem_addr_r;
    logic               overflow_r;
    logic               err_illegal_r;

    assign mnem_s = mnem_e'(in_mnem);

    // Encoder mux: field forcing for shifts/JR/LUI; codes outside the table are illegal.
    always_comb begin
        enc_word_s  = 32'h0000_0000;
        enc_legal_s = 1'b1;
        case (mnem_s)
            MN_ADD:  enc_word_s = r_word(in_rs, in_rt, in_rd, in_sa, FN_ADD);
            MN_SUB:  enc_word_s = r_word(in_rs, in_rt, in_rd, in_sa, FN_SUB);
            MN_AND:  enc_word_s = r_word(in_rs, in_rt, in_rd, in_sa, FN_AND);
            MN_OR:   enc_word_s = r_word(in_rs, in_rt, in_rd, in_sa, FN_OR);
            MN_XOR:  enc_word_s = r_word(in_rs, in_rt, in_rd, in_sa, FN_XOR);
            MN_SLL:  enc_word_s = r_word(5'd0, in_rt, in_rd, in_sa, FN_SLL);
            MN_SRL:  enc_word_s = r_word(5'd0, in_rt, in_rd, in_sa, FN_SRL);
            MN_SRA:  enc_word_s = r_word(5'd0, in_rt, in_rd, in_sa, FN_SRA);
            MN_JR:   enc_word_s = r_word(in_rs, 5'd0, 5'd0, 5'd0, FN_JR);
            MN_ADDI: enc_word_s = i_word(OP_ADDI, in_rs, in_rt, in_imm);
            MN_ANDI: enc_word_s = i_word(OP_ANDI, in_rs, in_rt, in_imm);
            MN_ORI:  enc_word_s = i_word(OP_ORI,  in_rs, in_rt, in_imm);
            MN_XORI: enc_word_s = i_word(OP_XORI, in_rs, in_rt, in_imm);
            MN_LW:   enc_word_s = i_word(OP_LW,   in_rs, in_rt, in_imm);
            MN_SW:   enc_word_s = i_word(OP_SW,   in_rs, in_rt, in_imm);
            MN_BEQ:  enc_word_s = i_word(OP_BEQ,  in_rs, in_rt, in_imm);
            MN_BNE:  enc_word_s = i_word(OP_BNE,  in_rs, in_rt, in_imm);
            MN_LUI:  enc_word_s = i_word(OP_LUI,  5'd0,  in_rt, in_imm);
            MN_J:    enc_word_s = j_word(OP_J,   in_target);
            MN_JAL:  enc_word_s = j_word(OP_JAL, in_target);
            default: enc_legal_s = 1'b0;
        endcase
    end

    // Words already written plus words still buffered must stay below imem capacity.
    assign occ_sum_s = SUM_W'(wr_count_r) + SUM_W'(fifo_count_s);
    assign cap_ok_s  = (occ_sum_s < CAP_L);
    assign in_ready  = ~fifo_full_s & cap_ok_s & ~clear;
    assign accept_s  = in_valid & in_ready;
    assign push_s    = accept_s & enc_legal_s;
    assign pop_s     = ~fifo_empty_s & mem_grant & ~clear;

    sc_word_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (enc_word_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Write address/count advance on each retired word; flags are sticky until reset/clear.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_count_r    <= {WCNT_W{1'b0}};
            mem_addr_r    <= BASE_L;
            overflow_r    <= 1'b0;
            err_illegal_r <= 1'b0;
        end else begin
            if (pop_s) begin
                wr_count_r <= wr_count_r + WCNT_W'(1);
                mem_addr_r <= mem_addr_r + ADDR_W'(1);
            end
            if (in_valid && !cap_ok_s) begin
                overflow_r <= 1'b1;
            end
            if (accept_s && !enc_legal_s) begin
                err_illegal_r <= 1'b1;
            end
        end
    end

    assign mem_we      = ~fifo_empty_s;
    assign mem_wdata   = fifo_rdata_s;
    assign mem_addr    = mem_addr_r;
    assign wr_count    = wr_count_r;
    assign overflow    = overflow_r;
    assign err_illegal = err_illegal_r;

`ifdef SC_ENC_CHECKSUM_EN
    logic [31:0] checksum_r;

    // Rotate-and-xor signature over every word retired to imem.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            checksum_r <= 32'h0000_0000;
        end else if (pop_s) begin
            checksum_r <= {checksum_r[30:0], checksum_r[31]} ^ fifo_rdata_s;
        end else begin
            checksum_r <= checksum_r;
        end
    end

    assign checksum = checksum_r;
`endif

endmodule
